// File: rtl/multiplier.sv
`default_nettype none
// ============================================================================
// multiplier : iterative shift-add unsigned multiplier, one partial product per clock
// Revision   : 1.0
// ============================================================================
module multiplier #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                      Clk,
  input  logic                      nReset,
  input  logic [DATA_WIDTH-1:0]     InputA,
  input  logic [DATA_WIDTH-1:0]     InputB,
  input  logic                      Start,
  output logic [2*DATA_WIDTH-1:0]   Product,
  output logic                      Ready
);

  localparam int              CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] c_steps = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);
  localparam logic [0:0]      c_idle   = 1'b0;
  localparam logic [0:0]      c_run    = 1'b1;

  logic [0:0]              r_state;
  logic [0:0]              w_state_next;
  logic [2*DATA_WIDTH-1:0] r_mcand;
  logic [2*DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0]   r_mplier;
  logic [CNT_W-1:0]        r_count;
  logic [2*DATA_WIDTH-1:0] w_acc_sum;
  logic                    w_last_step;
  logic                    w_accept;

  assign w_acc_sum   = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_last_step = (r_count == c_one);
  assign w_accept    = (r_state == c_idle) && Start;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_idle:  if (Start) w_state_next = c_run;
      c_run:   if (w_last_step) w_state_next = c_idle;
      default: w_state_next = c_idle;
    endcase
  end

  always_comb begin
    Ready = (r_state == c_idle);
  end

  // Product is written only on the final step so partial sums never appear.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      Product  <= '0;
    end else if (w_accept) begin
      r_mcand  <= {{DATA_WIDTH{1'b0}}, InputA};
      r_mplier <= InputB;
      r_acc    <= '0;
      r_count  <= c_steps;
    end else if (r_state == c_run) begin
      r_acc    <= w_acc_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count - c_one;
      if (w_last_step) begin
        Product <= w_acc_sum;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multiplier.sv
`default_nettype none
// ============================================================================
// tb_multiplier : directed-vector self-checking bench for multiplier (16-bit)
// Revision      : 1.0
// ============================================================================
module tb_multiplier;

  logic        Clk;
  logic        nReset;
  logic [15:0] InputA;
  logic [15:0] InputB;
  logic        Start;
  logic [31:0] Product;
  logic        Ready;

  int total = 0;
  int bad   = 0;

  multiplier #(.DATA_WIDTH(16)) dut (
    .Clk     (Clk),
    .nReset  (nReset),
    .InputA  (InputA),
    .InputB  (InputB),
    .Start   (Start),
    .Product (Product),
    .Ready   (Ready)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One operation; optionally disturbs inputs and pulses Start while busy.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp, input bit disturb);
    logic [31:0] prev;
    int          busy;
    bit          held;
    check({tag, "_ready_before"}, 64'(Ready), 64'd1);
    prev   = Product;
    InputA = a;
    InputB = b;
    Start  = 1'b1;
    tick();
    Start = 1'b0;
    busy  = 0;
    held  = 1'b1;
    while (Ready == 1'b0 && busy < 200) begin
      busy++;
      if (Product !== prev) held = 1'b0;
      if (disturb && busy == 3) begin
        InputA = 16'd9;
        InputB = 16'd9;
        Start  = 1'b1;
      end
      if (disturb && busy == 5) Start = 1'b0;
      tick();
    end
    check({tag, "_busy_cycles"}, 64'(busy), 64'd16);
    check({tag, "_held"}, 64'(held), 64'd1);
    check({tag, "_product"}, 64'(Product), 64'(exp));
  endtask

  initial begin
    int high;
    int busy;
    nReset = 1'b0;
    InputA = '0;
    InputB = '0;
    Start  = 1'b0;
    #2;
    check("reset_ready", 64'(Ready), 64'd1);
    check("reset_product", 64'(Product), 64'd0);
    // Start while in reset must be ignored.
    Start = 1'b1;
    InputA = 16'd7;
    InputB = 16'd7;
    tick();
    tick();
    check("start_in_reset_ready", 64'(Ready), 64'd1);
    @(negedge Clk);
    Start  = 1'b0;
    nReset = 1'b1;
    tick();
    check("post_release_idle", 64'(Ready), 64'd1);

    run_op("basic", 16'd4, 16'd5, 32'd20, 1'b0);
    run_op("max", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b0);
    run_op("zero", 16'd0, 16'h1234, 32'd0, 1'b0);
    run_op("one", 16'd1, 16'hBEEF, 32'h0000BEEF, 1'b0);
    run_op("mixed", 16'h8001, 16'h0003, 32'h00018003, 1'b0);

    // Idle with Start low holds everything.
    tick();
    tick();
    tick();
    check("idle_hold_ready", 64'(Ready), 64'd1);
    check("idle_hold_product", 64'(Product), 64'h00018003);

    run_op("isolate", 16'd3, 16'd7, 32'd21, 1'b1);
    tick();
    tick();
    check("isolate_no_restart", 64'(Ready), 64'd1);
    check("isolate_product_stable", 64'(Product), 64'd21);

    // Reset in the middle of an operation.
    InputA = 16'd100;
    InputB = 16'd200;
    Start  = 1'b1;
    tick();
    Start = 1'b0;
    check("midreset_busy", 64'(Ready), 64'd0);
    for (int i = 0; i < 4; i++) tick();
    nReset = 1'b0;
    #1;
    check("midreset_ready", 64'(Ready), 64'd1);
    check("midreset_product", 64'(Product), 64'd0);
    @(negedge Clk);
    nReset = 1'b1;
    tick();
    check("midreset_after_release", 64'(Product), 64'd0);
    run_op("after_reset", 16'd100, 16'd200, 32'd20000, 1'b0);

    // Back-to-back with Start held high.
    InputA = 16'd2;
    InputB = 16'd3;
    Start  = 1'b1;
    tick();
    for (int op = 0; op < 2; op++) begin
      busy = 0;
      while (Ready == 1'b0 && busy < 200) begin
        busy++;
        tick();
      end
      check($sformatf("b2b%0d_busy", op), 64'(busy), 64'd16);
      check($sformatf("b2b%0d_product", op), 64'(Product), 64'd6);
      high = 0;
      while (Ready == 1'b1 && high < 50) begin
        high++;
        tick();
      end
      check($sformatf("b2b%0d_ready_high", op), 64'(high), 64'd1);
    end
    Start = 1'b0;
    busy = 0;
    while (Ready == 1'b0 && busy < 200) begin
      busy++;
      tick();
    end
    check("b2b_final_product", 64'(Product), 64'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multiplier.md
MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 16, operand width in bits (legal range 2..32).
REQ-002 SHALL provide port Clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port nReset  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port InputA  input  DATA_WIDTH  unsigned multiplicand.
REQ-005 SHALL provide port InputB  input  DATA_WIDTH  unsigned multiplier.
REQ-006 SHALL provide port Start  input  1  level request to begin a multiplication.
REQ-007 SHALL provide port Product  output  2*DATA_WIDTH  registered unsigned result.
REQ-008 SHALL provide port Ready  output  1  high = idle, Product valid, Start accepted.

Function
REQ-009 SHALL implement a two-state FSM: IDLE (Ready=1) and RUN (Ready=0).
REQ-010 In IDLE, a rising edge with Start=1 SHALL accept an operation: capture InputA and InputB into internal registers, clear the internal accumulator, load the iteration counter with DATA_WIDTH, and enter RUN (Ready=0 after that edge).
REQ-011 In IDLE with Start=0, the block SHALL hold its state, Ready=1 and Product unchanged.
REQ-012 In RUN, each rising edge SHALL perform one shift-add step: if the captured multiplier LSB is 1, add the shifted multiplicand to the 2*DATA_WIDTH accumulator; then shift the multiplicand left by 1, shift the multiplier right by 1, and decrement the counter.
REQ-013 The operation SHALL complete on the edge performing the DATA_WIDTH-th step: write the final accumulator to Product, set Ready=1, and return to IDLE.
REQ-014 Latency: Ready SHALL be low for exactly DATA_WIDTH clock cycles per operation (16 for the default).
REQ-015 Product SHALL equal InputA*InputB exactly (unsigned, full 2*DATA_WIDTH width, no truncation or overflow).
REQ-016 Product SHALL hold the previous result throughout RUN and change only at completion; no partial sums appear on Product.
REQ-017 Changes on InputA/InputB after the accept edge SHALL NOT affect the running operation.
REQ-018 Start during RUN SHALL be ignored; it neither restarts nor queues an operation.
REQ-019 Start is level-sensitive: if Start=1 on the first IDLE edge after completion, a new operation SHALL be accepted on that edge using the current inputs; users deassert Start after Ready falls.
REQ-020 Zero operands SHALL still take the full DATA_WIDTH cycles (no early termination).

Reset
REQ-021 Assertion of nReset=0 SHALL immediately, without a clock, force state IDLE, Ready=1, Product=0, and clear the accumulator, operand and counter registers.
REQ-022 Reset asserted during RUN SHALL abort the operation; after release, Product=0 and Ready=1 until a new Start is accepted.
REQ-023 While nReset=0, Start SHALL be ignored; the first acceptance is on the first rising edge after release with Start=1.

Verification
REQ-024 Basic: after reset, wait Ready=1, apply A=4, B=5, Start=1, drop Start once Ready=0 -> Ready returns to 1 and Product=20.
REQ-025 Extremes (DATA_WIDTH=16): A=16'hFFFF, B=16'hFFFF -> Product=32'hFFFE0001; A=0, B=16'h1234 -> Product=0; A=1, B=16'hBEEF -> Product=32'h0000BEEF.
REQ-026 Latency: count cycles with Ready=0 after an accept -> exactly 16; Product equals its previous value on every cycle before completion.
REQ-027 Busy isolation: start A=3, B=7; during RUN change inputs to A=9, B=9 and pulse Start -> Product=21, a single 16-cycle busy window, no restart.
REQ-028 Reset mid-operation: start A=100, B=200, assert nReset after 5 busy cycles -> Ready=1 and Product=0 immediately; after release, new op A=100, B=200 -> Product=20000.
REQ-029 Back-to-back: hold Start=1 continuously with A=2, B=3 -> consecutive operations each give Product=6 with Ready high for exactly one cycle between them.
